// File: rtl/com_bus_arbiter_pkg.sv
// Shared definitions for the coherence-bus arbiter: default sizes and FSM state types.
package com_bus_arbiter_pkg;

  localparam int DEF_N_PROC   = 8;
  localparam int DEF_N_SNOOP  = 4;
  localparam int DEF_MAX_HOLD = 1024;

  typedef enum logic {P_IDLE, P_OWN} proc_state_t;
  typedef enum logic {S_IDLE, S_OWN} snp_state_t;

endpackage

// File: rtl/com_bus_arbiter_if.sv
// Request/grant bundle between the cache wrappers (master) and the bus arbiter (slave).
interface com_bus_arbiter_if
  import com_bus_arbiter_pkg::*;
#(
  parameter int N_PROC  = DEF_N_PROC,
  parameter int N_SNOOP = DEF_N_SNOOP
);

  logic [N_PROC-1:0]  Com_Bus_Req_proc;
  logic [N_PROC-1:0]  Com_Bus_Gnt_proc;
  logic [N_SNOOP-1:0] Com_Bus_Req_snoop;
  logic [N_SNOOP-1:0] Com_Bus_Gnt_snoop;
  logic               Bus_busy;
  logic               Bus_timeout;

  modport master (
    output Com_Bus_Req_proc, Com_Bus_Req_snoop,
    input  Com_Bus_Gnt_proc, Com_Bus_Gnt_snoop, Bus_busy, Bus_timeout
  );

  modport slave (
    input  Com_Bus_Req_proc, Com_Bus_Req_snoop,
    output Com_Bus_Gnt_proc, Com_Bus_Gnt_snoop, Bus_busy, Bus_timeout
  );

endinterface

// File: rtl/com_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_pick #(
  parameter int N  = 8,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          valid,
  output logic [PW-1:0] idx
);

  int j;

  // Scan from the farthest candidate back to ptr so the nearest hit wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    j     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (req[j]) begin
        valid = 1'b1;
        idx   = PW'(j);
      end
    end
  end

endmodule

// File: rtl/com_bus_arbiter.sv
// Coherence-bus arbiter: round-robin ownership, nested snoop grant inside the owner's
// tenure, and a sticky hold-time watchdog.
module com_bus_arbiter
  import com_bus_arbiter_pkg::*;
#(
  parameter int N_PROC   = DEF_N_PROC,
  parameter int N_SNOOP  = DEF_N_SNOOP,
  parameter int MAX_HOLD = DEF_MAX_HOLD,
  parameter int CNT_W    = $clog2(MAX_HOLD + 1)
) (
  input logic              clk,
  input logic              rst,
  com_bus_arbiter_if.slave bus
);

  localparam int PPW = (N_PROC > 1) ? $clog2(N_PROC) : 1;
  localparam int SPW = (N_SNOOP > 1) ? $clog2(N_SNOOP) : 1;

  proc_state_t        proc_state, proc_next;
  snp_state_t         snp_state, snp_next;
  logic [PPW-1:0]     pp, owner, p_idx;
  logic [SPW-1:0]     sp, snp_idx, s_idx;
  logic               p_valid, s_valid;
  logic [N_SNOOP-1:0] snp_elig;
  logic [CNT_W-1:0]   hold_cnt;
  logic               timeout;

  rr_pick #(.N(N_PROC), .PW(PPW)) u_proc_pick (
    .req   (bus.Com_Bus_Req_proc),
    .ptr   (pp),
    .valid (p_valid),
    .idx   (p_idx)
  );

  // Snoops only make sense during a tenure, and the owner never snoops itself.
  always_comb begin
    snp_elig = '0;
    for (int i = 0; i < N_SNOOP; i++)
      snp_elig[i] = bus.Com_Bus_Req_snoop[i] && (proc_state == P_OWN) && (owner != PPW'(i));
  end

  rr_pick #(.N(N_SNOOP), .PW(SPW)) u_snp_pick (
    .req   (snp_elig),
    .ptr   (sp),
    .valid (s_valid),
    .idx   (s_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      proc_state <= P_IDLE;
      pp         <= '0;
      owner      <= '0;
    end else begin
      proc_state <= proc_next;
      if (proc_state == P_IDLE && p_valid) begin
        owner <= p_idx;
        pp    <= (p_idx == PPW'(N_PROC - 1)) ? '0 : p_idx + 1'b1;
      end
    end
  end

  // The owner keeps the bus until it has dropped its request and no snoop is in flight.
  always_comb begin
    proc_next = proc_state;
    case (proc_state)
      P_IDLE:  if (p_valid) proc_next = P_OWN;
      P_OWN:   if (!bus.Com_Bus_Req_proc[owner] && snp_state == S_IDLE) proc_next = P_IDLE;
      default: proc_next = P_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snp_state <= S_IDLE;
      sp        <= '0;
      snp_idx   <= '0;
    end else begin
      snp_state <= snp_next;
      if (snp_state == S_IDLE && s_valid) begin
        snp_idx <= s_idx;
        sp      <= (s_idx == SPW'(N_SNOOP - 1)) ? '0 : s_idx + 1'b1;
      end
    end
  end

  always_comb begin
    snp_next = snp_state;
    case (snp_state)
      S_IDLE:  if (s_valid) snp_next = S_OWN;
      S_OWN:   if (!bus.Com_Bus_Req_snoop[snp_idx]) snp_next = S_IDLE;
      default: snp_next = S_IDLE;
    endcase
  end

  // Counts clock edges spent owning the bus; the grant is never revoked, only flagged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= '0;
      timeout  <= 1'b0;
    end else if (proc_state == P_IDLE) begin
      if (p_valid) hold_cnt <= '0;
    end else begin
      if (hold_cnt < CNT_W'(MAX_HOLD)) hold_cnt <= hold_cnt + 1'b1;
      if (hold_cnt >= CNT_W'(MAX_HOLD - 1)) timeout <= 1'b1;
    end
  end

  always_comb begin
    bus.Com_Bus_Gnt_proc  = '0;
    bus.Com_Bus_Gnt_snoop = '0;
    if (proc_state == P_OWN) bus.Com_Bus_Gnt_proc[owner]  = 1'b1;
    if (snp_state == S_OWN)  bus.Com_Bus_Gnt_snoop[snp_idx] = 1'b1;
    bus.Bus_busy    = (proc_state == P_OWN);
    bus.Bus_timeout = timeout;
  end

endmodule

// File: doc/com_bus_arbiter.md
# com_bus_arbiter

Arbiter for the shared coherence bus (Address_Com / Data_Bus_Com) in the 4-core MESI system. It issues the `Com_Bus_Gnt_proc[7:0]` and `Com_Bus_Gnt_snoop[3:0]` grants that the cache wrappers wait on:
- proc indices 0–3 are the D-caches of cores 0–3.
- proc indices 4–7 are the I-caches.
- snoop indices 0–3 are the D-caches acting as snoop responders (flush or supply data).

The arbiter uses round-robin for bus ownership, a nested snoop grant within the owner's tenure, and a hold-time watchdog.

## Interface
- N_PROC, 8, number of processor-side requesters
- N_SNOOP, 4, number of snoop-side requesters (map to proc indices 0..N_SNOOP-1)
- MAX_HOLD, 1024, owner-tenure cycles before timeout is flagged
- CNT_W, $clog2(MAX_HOLD+1), hold-counter width
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- Com_Bus_Req_proc  input  N_PROC  ownership requests, level, held until transaction complete
- Com_Bus_Gnt_proc  output  N_PROC  one-hot-or-zero ownership grant, registered
- Com_Bus_Req_snoop  input  N_SNOOP  snoop-response requests, level
- Com_Bus_Gnt_snoop  output  N_SNOOP  one-hot-or-zero snoop grant, registered
- Bus_busy  output  1  high while any proc grant is active
- Bus_timeout  output  1  sticky; set when a tenure exceeds MAX_HOLD, cleared only by rst

## Operation
- **Proc FSM states:**
  - P_IDLE: if any Req_proc, pick winner w by round-robin from pointer pp; Gnt_proc[w] <= 1; pp <= (w+1) mod N_PROC; go to P_OWN.
  - P_OWN: hold grant while Req_proc[w] = 1 or any Gnt_snoop is active. When Req_proc[w] = 0 and no snoop grant is active, Gnt_proc <= 0 and go to P_IDLE.
- **Round-robin:** search indices pp, pp+1, …, wrapping N_PROC-1 to 0; the first asserted index wins.
- **Snoop FSM states:**
  - S_IDLE: eligible set = Req_snoop masked by (Bus_busy) and excluding index w when w < N_SNOOP (a cache never snoops its own transaction). If eligible is nonzero, pick by round-robin from pointer sp; Gnt_snoop[s] <= 1; sp <= (s+1) mod N_SNOOP; go to S_OWN.
  - S_OWN: hold while Req_snoop[s] = 1; on drop, Gnt_snoop <= 0 and go to S_IDLE.
  - Snoop requests raised with no owner stay pending and are never granted until an owner exists.
- **Hold counter:**
  - Clears on entry to P_OWN and increments each P_OWN cycle, saturating at MAX_HOLD.
  - Reaching MAX_HOLD sets Bus_timeout.
  - Grant is NOT revoked on timeout.
- **Reset values:** all grants 0, Bus_busy 0, Bus_timeout 0, pp = 0, sp = 0, counter 0, both FSMs idle. Reset mid-tenure drops grants asynchronously.
- **Invariant:** at most one proc grant and at most one snoop grant at any time.

## Timing
- Request sampled at edge N → grant visible after edge N+1 (1-cycle latency).
- Owner drops its request before edge N → grant low after edge N. The earliest next proc grant is after edge N+1, giving one mandatory idle bubble cycle.
- Snoop grant: earliest one cycle after the proc grant rises. Snoop release and re-grant follow the same bubble rule.
- Owner request drops while a snoop grant is active → proc grant held until the cycle after the snoop grant falls.
- Simultaneous requests: only the round-robin winner is granted; the others wait, with no starvation (bound ≤ N_PROC-1 tenures).
- Bus_busy is equal to OR of Gnt_proc (registered, same cycle).

## Structure
- **Shared package** holds:
  - N_PROC, N_SNOOP defaults.
  - State enums proc_state_t {P_IDLE, P_OWN} and snp_state_t {S_IDLE, S_OWN}.
- **Sub-module rr_pick** (parameter N): inputs req[N], ptr; outputs valid and idx. It is combinational and instantiated once for proc and once for snoop.
- **Top module** holds the two FSMs, the pointers, the hold counter and the sticky flag.

## Test plan
- Req_proc = 8'b0000_0100 at cycle 2 → Gnt_proc = 8'b0000_0100 at cycle 3; Req drop at 10 → Gnt 0 at 11; Bus_busy tracks Gnt.
- Req_proc = 8'b0010_0001 simultaneously from reset → grant bit 0 first; after its release and the bubble → bit 5. Then pp = 6.
- Wrap: pp = 6, requests on bits 7 and 1 → 7 granted, then 1; pp ends at 2.
- Nested snoop: proc 1 owns, Req_snoop = 4'b1010 → Gnt_snoop = 4'b1000 only (bit 1 masked). Owner drops request mid-snoop → Gnt_proc stays until the cycle after Gnt_snoop falls.
- Snoop request with no owner for 20 cycles → Gnt_snoop stays 0. It is granted one cycle after a proc grant appears.
- MAX_HOLD = 16, owner holds 30 cycles → Bus_timeout rises at tenure cycle 16 and stays high after release. Asserting rst mid-tenure → all outputs 0 immediately, pp = 0.
